// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - Burst reader draining a FWFT FIFO into AXI-Stream packets
//
// Waits until BURST_LEN words are buffered in the FIFO, then pops them and
// emits one packet with m_axis_tlast on the final beat. The output stage is
// registered, so a pop only happens when the output register is free or
// being drained in the same cycle.
//
// Optional feature (macro FIFO_BURST_READER_TIMEOUT_EN): a partial FIFO that
// sits idle for TIMEOUT_CYCLES is flushed as a short packet.
//
// Ports:
//   clk, rst_n        read-domain clock, synchronous active-low reset
//   enable            allows new bursts to start (sampled in IDLE)
//   fifo_rd_data      FIFO head word (first-word-fall-through)
//   fifo_empty        FIFO empty flag
//   fifo_count        FIFO read-side occupancy, ADDR_WIDTH+1 bits
//   fifo_rd_en        pop strobe (combinational)
//   m_axis_t*         AXI-Stream master (tdata/tvalid/tready/tlast)
//   busy              high in BURST or while an output beat is pending
//   pkt_count         packets whose tlast beat was accepted (wraps)
//   underrun          sticky: FIFO seen empty while in BURST
module fifo_burst_reader #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int BURST_LEN      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic [31:0]           pkt_count,
    output logic                  underrun
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);

    if (BURST_LEN < 1 || BURST_LEN > (1 << ADDR_WIDTH)) begin : g_bad_burst_len
        $fatal(1, "fifo_burst_reader: BURST_LEN out of range 1..2^ADDR_WIDTH");
    end

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]         cur_len_q, cur_len_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [31:0]           pkt_count_q, pkt_count_d;
    logic                  underrun_q, underrun_d;

    logic pop;
    logic last_beat;

    // A pop needs data at the head and an output register that is either
    // empty or handing its beat over in this same cycle.
    assign pop       = (state_q == BURST) && !fifo_empty && (!tvalid_q || m_axis_tready);
    assign last_beat = (beat_cnt_q == cur_len_q - CW'(1));

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $fatal(1, "fifo_burst_reader: TIMEOUT_CYCLES must be >= 1");
    end

    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            cur_len_q   <= BURST_LEN_C;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            pkt_count_q <= '0;
            underrun_q  <= 1'b0;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            cur_len_q   <= cur_len_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            pkt_count_q <= pkt_count_d;
            underrun_q  <= underrun_d;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        cur_len_d  = cur_len_q;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        idle_cnt_d = '0;
`endif
        case (state_q)
            IDLE: begin
                if (enable && (fifo_count >= BURST_LEN_C)) begin
                    state_d    = BURST;
                    cur_len_d  = BURST_LEN_C;
                    beat_cnt_d = '0;
                end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
                // Partial data with nothing else happening: count towards a flush.
                else if (enable && (fifo_count != '0)) begin
                    if (idle_cnt_q == IW'(TIMEOUT_CYCLES - 1)) begin
                        state_d    = BURST;
                        cur_len_d  = fifo_count;
                        beat_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IW'(1);
                    end
                end
`endif
            end
            BURST: begin
                if (pop) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: registered stream stage plus status
    always_comb begin
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        if (pop) begin
            tdata_d  = fifo_rd_data;
            tvalid_d = 1'b1;
            tlast_d  = last_beat;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
        pkt_count_d = pkt_count_q;
        if (tvalid_q && m_axis_tready && tlast_q) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end
        underrun_d  = underrun_q || ((state_q == BURST) && fifo_empty);
    end

    assign fifo_rd_en    = pop;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = (state_q == BURST) || tvalid_q;
    assign pkt_count     = pkt_count_q;
    assign underrun      = underrun_q;

endmodule
